// File: rtl/dcache_wb_pkg.sv
// ---------------------------------------------------------------------------
// dcache_wb_pkg
// Shared definitions for the write-back data cache: controller state
// encoding, default geometry and address index/tag helpers.
// ---------------------------------------------------------------------------
package dcache_wb_pkg;

  localparam int ADDR_W         = 16;
  localparam int WORD_W         = 16;
  localparam int INDEX_BITS_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WB    = 2'd1,
    ST_FILL  = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  // Line index of a word address, returned zero-extended to ADDR_W.
  function automatic logic [ADDR_W-1:0] addr_index(input logic [ADDR_W-1:0] addr,
                                                   input int index_bits);
    return addr & ((ADDR_W'(1) << index_bits) - ADDR_W'(1));
  endfunction

  // Tag of a word address, returned right-aligned in ADDR_W bits.
  function automatic logic [ADDR_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr,
                                                 input int index_bits);
    return addr >> index_bits;
  endfunction

  // Rebuilds a word address from a right-aligned tag and a line index.
  function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] tag,
                                                  input logic [ADDR_W-1:0] idx,
                                                  input int index_bits);
    return (tag << index_bits) | addr_index(idx, index_bits);
  endfunction

endpackage

// File: rtl/dcache_wb_if.sv
// ---------------------------------------------------------------------------
// dcache_wb_if
// Bus bundle for the cache controller: CPU MEM-stage request/response
// signals, flush control, and the main-memory request/response signals.
//   slave  : the cache controller's view
//   master : the surrounding system (CPU + main memory) view
// ---------------------------------------------------------------------------
interface dcache_wb_if;
  import dcache_wb_pkg::*;

  // CPU side
  logic [ADDR_W-1:0] cpu_addr;
  logic [WORD_W-1:0] cpu_wr_data;
  logic              cpu_rd;
  logic              cpu_wr;
  logic [WORD_W-1:0] cpu_rd_data;
  logic              stall;
  logic              flush;
  logic              flush_done;

  // Main-memory side
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wr_data;
  logic              mem_rd_req;
  logic              mem_wr_req;
  logic [WORD_W-1:0] mem_rd_data;
  logic              mem_ready;

  modport slave (
    input  cpu_addr, cpu_wr_data, cpu_rd, cpu_wr, flush, mem_rd_data, mem_ready,
    output cpu_rd_data, stall, flush_done, mem_addr, mem_wr_data, mem_rd_req, mem_wr_req
  );

  modport master (
    output cpu_addr, cpu_wr_data, cpu_rd, cpu_wr, flush, mem_rd_data, mem_ready,
    input  cpu_rd_data, stall, flush_done, mem_addr, mem_wr_data, mem_rd_req, mem_wr_req
  );

endinterface

// File: rtl/dcache_array.sv
// ---------------------------------------------------------------------------
// dcache_array
// Storage for the direct-mapped cache: per-line valid, dirty, tag and one
// data word.
//   idx          : line index shared by the read port and the write port
//   rd_*         : combinational read of the addressed line
//   wr_line_en   : write tag and data of the addressed line
//   wr_valid_en  : write the valid bit (wr_valid)
//   wr_dirty_en  : write the dirty bit (wr_dirty)
// Valid and dirty bits clear on synchronous reset; tag/data are not reset.
// ---------------------------------------------------------------------------
module dcache_array
  import dcache_wb_pkg::*;
#(
  parameter int INDEX_BITS = INDEX_BITS_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [INDEX_BITS-1:0]          idx,
  output logic                           rd_valid,
  output logic                           rd_dirty,
  output logic [ADDR_W-INDEX_BITS-1:0]   rd_tag,
  output logic [WORD_W-1:0]              rd_data,
  input  logic                           wr_line_en,
  input  logic [ADDR_W-INDEX_BITS-1:0]   wr_tag,
  input  logic [WORD_W-1:0]              wr_data,
  input  logic                           wr_valid_en,
  input  logic                           wr_valid,
  input  logic                           wr_dirty_en,
  input  logic                           wr_dirty
);

  localparam int TAG_BITS = ADDR_W - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;

  logic [LINES-1:0]    valid_q;
  logic [LINES-1:0]    dirty_q;
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [WORD_W-1:0]   data_mem [LINES];

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_mem[idx];
  assign rd_data  = data_mem[idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (wr_valid_en) valid_q[idx] <= wr_valid;
      if (wr_dirty_en) dirty_q[idx] <= wr_dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_line_en) begin
      tag_mem[idx]  <= wr_tag;
      data_mem[idx] <= wr_data;
    end
  end

endmodule

// File: rtl/dcache_wb.sv
// ---------------------------------------------------------------------------
// dcache_wb
// Write-back, write-allocate, direct-mapped data cache controller, one
// 16-bit word per line.
//   clk   : clock, all state updates on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : dcache_wb_if.slave
//           CPU: cpu_addr/cpu_wr_data/cpu_rd/cpu_wr in, cpu_rd_data/stall out
//           flush in, flush_done out (one-cycle registered pulse)
//           memory: mem_addr/mem_wr_data/mem_rd_req/mem_wr_req out,
//                   mem_rd_data/mem_ready in
// Hits complete in the request cycle. A miss writes back a dirty victim
// (WB), refills the line (FILL) and then completes as a hit in IDLE.
// Flush walks every line and writes back the dirty ones.
// ---------------------------------------------------------------------------
module dcache_wb
  import dcache_wb_pkg::*;
#(
  parameter int INDEX_BITS = INDEX_BITS_DEF
) (
  input logic        clk,
  input logic        rst_n,
  dcache_wb_if.slave bus
);

  localparam int TAG_BITS = ADDR_W - INDEX_BITS;

  state_e                state_q, state_d;
  logic [INDEX_BITS:0]   cnt_q, cnt_d, cnt_inc;
  logic                  flush_done_q, flush_done_d;
  logic                  advance;

  logic [INDEX_BITS-1:0] cpu_idx, arr_idx;
  logic [TAG_BITS-1:0]   cpu_tag;
  logic                  req, hit;
  logic [ADDR_W-1:0]     victim_addr;

  logic                  rd_valid, rd_dirty;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [WORD_W-1:0]     rd_data;
  logic                  wr_line_en, wr_valid_en, wr_dirty_en, wr_dirty;
  logic [TAG_BITS-1:0]   wr_tag;
  logic [WORD_W-1:0]     wr_data;

  assign cpu_idx = bus.cpu_addr[INDEX_BITS-1:0];
  assign cpu_tag = bus.cpu_addr[ADDR_W-1:INDEX_BITS];
  assign req     = bus.cpu_rd | bus.cpu_wr;

  // The flush walk owns the array index; otherwise the CPU address does.
  assign arr_idx = (state_q == ST_FLUSH) ? cnt_q[INDEX_BITS-1:0] : cpu_idx;
  assign hit     = rd_valid && (rd_tag == cpu_tag);

  // Memory address of the line currently selected by arr_idx.
  assign victim_addr = line_addr({{INDEX_BITS{1'b0}}, rd_tag},
                                 {{TAG_BITS{1'b0}}, arr_idx}, INDEX_BITS);

  // The extra counter bit carries out when the last line has been handled.
  assign cnt_inc = cnt_q + {{INDEX_BITS{1'b0}}, 1'b1};

  dcache_array #(.INDEX_BITS(INDEX_BITS)) u_array (
    .clk         (clk),
    .rst_n       (rst_n),
    .idx         (arr_idx),
    .rd_valid    (rd_valid),
    .rd_dirty    (rd_dirty),
    .rd_tag      (rd_tag),
    .rd_data     (rd_data),
    .wr_line_en  (wr_line_en),
    .wr_tag      (wr_tag),
    .wr_data     (wr_data),
    .wr_valid_en (wr_valid_en),
    .wr_valid    (1'b1),
    .wr_dirty_en (wr_dirty_en),
    .wr_dirty    (wr_dirty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign bus.flush_done = flush_done_q;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    flush_done_d    = 1'b0;
    advance         = 1'b0;
    bus.stall       = 1'b0;
    bus.cpu_rd_data = '0;
    bus.mem_rd_req  = 1'b0;
    bus.mem_wr_req  = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wr_data = '0;
    wr_line_en      = 1'b0;
    wr_tag          = cpu_tag;
    wr_data         = bus.cpu_wr_data;
    wr_valid_en     = 1'b0;
    wr_dirty_en     = 1'b0;
    wr_dirty        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (hit) begin
            // A simultaneous rd+wr is a store; read data is then don't-care.
            if (bus.cpu_wr) begin
              wr_line_en  = 1'b1;
              wr_dirty_en = 1'b1;
              wr_dirty    = 1'b1;
            end else begin
              bus.cpu_rd_data = rd_data;
            end
          end else begin
            bus.stall = 1'b1;
            state_d   = (rd_valid && rd_dirty) ? ST_WB : ST_FILL;
          end
        end else if (bus.flush) begin
          bus.stall = 1'b1;
          state_d   = ST_FLUSH;
          cnt_d     = '0;
        end
      end

      ST_WB: begin
        bus.stall       = 1'b1;
        bus.mem_wr_req  = 1'b1;
        bus.mem_addr    = victim_addr;
        bus.mem_wr_data = rd_data;
        if (bus.mem_ready) begin
          wr_dirty_en = 1'b1;
          state_d     = ST_FILL;
        end
      end

      ST_FILL: begin
        bus.stall      = 1'b1;
        bus.mem_rd_req = 1'b1;
        bus.mem_addr   = bus.cpu_addr;
        if (bus.mem_ready) begin
          // Line becomes valid and clean; a pending store lands next cycle as a hit.
          wr_line_en  = 1'b1;
          wr_data     = bus.mem_rd_data;
          wr_valid_en = 1'b1;
          wr_dirty_en = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      ST_FLUSH: begin
        bus.stall = 1'b1;
        if (rd_valid && rd_dirty) begin
          bus.mem_wr_req  = 1'b1;
          bus.mem_addr    = victim_addr;
          bus.mem_wr_data = rd_data;
          if (bus.mem_ready) begin
            wr_dirty_en = 1'b1;
            advance     = 1'b1;
          end
        end else begin
          advance = 1'b1;
        end
        if (advance) begin
          cnt_d = cnt_inc;
          if (cnt_inc[INDEX_BITS]) begin
            flush_done_d = 1'b1;
            state_d      = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_wb.sv
// Bench for dcache_wb. The reference model is the CPU-visible memory image:
// every load must return the last value stored to that address, and after a
// flush the backing memory must equal that image. Reset discards the cache,
// so the image is rebuilt from backing memory at that point.
module tb_dcache_wb;
  import dcache_wb_pkg::*;

  localparam int IB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dcache_wb_if bus();

  dcache_wb #(.INDEX_BITS(IB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [15:0] data;
  } mem_txn_t;

  logic [15:0] bmem    [65536];
  logic [15:0] ref_mem [65536];
  logic [15:0] exp_q   [$];
  mem_txn_t    mem_log [$];

  int n_checks = 0;
  int n_fail   = 0;
  int mem_lat  = 1;
  bit spur     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory responder: mem_ready arrives in the mem_lat-th cycle of a request.
  initial begin
    bit busy;
    int wait_left;
    busy = 1'b0;
    wait_left = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rd_data = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_ready) begin
        bus.mem_ready = 1'b0;
        busy = 1'b0;
      end
      if (!rst_n) begin
        busy = 1'b0;
      end else if (bus.mem_rd_req || bus.mem_wr_req) begin
        if (!busy) begin
          busy = 1'b1;
          wait_left = mem_lat - 1;
        end
        if (wait_left <= 0) begin
          bus.mem_ready = 1'b1;
          if (bus.mem_wr_req) begin
            bmem[bus.mem_addr] = bus.mem_wr_data;
            mem_log.push_back('{wr: 1'b1, addr: bus.mem_addr, data: bus.mem_wr_data});
          end else begin
            bus.mem_rd_data = bmem[bus.mem_addr];
            mem_log.push_back('{wr: 1'b0, addr: bus.mem_addr, data: bmem[bus.mem_addr]});
          end
        end else begin
          wait_left--;
        end
      end else begin
        busy = 1'b0;
        if (spur) bus.mem_ready = 1'b1;
      end
    end
  end

  // Load scoreboard: one pop per completed load.
  initial forever begin
    @(negedge clk);
    #1;
    if (rst_n && bus.cpu_rd && !bus.cpu_wr && !bus.stall) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_unexpected: load data 0x%0h presented with no load outstanding", bus.cpu_rd_data);
      end else begin
        check("rd_data", 32'(bus.cpu_rd_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // Memory protocol monitor: exclusive requests, held stable until mem_ready.
  initial begin
    bit p_rd, p_wr, p_ready, p_rst;
    logic [15:0] p_addr, p_wdata;
    p_rd = 1'b0; p_wr = 1'b0; p_ready = 1'b0; p_rst = 1'b0;
    p_addr = '0; p_wdata = '0;
    forever begin
      @(negedge clk);
      #1;
      if (bus.mem_rd_req || bus.mem_wr_req)
        check("req_exclusive", 32'(bus.mem_rd_req & bus.mem_wr_req), 32'(0));
      if (p_rst && (p_rd || p_wr) && !p_ready) begin
        check("req_hold", 32'({bus.mem_rd_req, bus.mem_wr_req}), 32'({p_rd, p_wr}));
        check("addr_hold", 32'(bus.mem_addr), 32'(p_addr));
        if (p_wr) check("wdata_hold", 32'(bus.mem_wr_data), 32'(p_wdata));
      end
      p_rd = bus.mem_rd_req;
      p_wr = bus.mem_wr_req;
      p_addr = bus.mem_addr;
      p_wdata = bus.mem_wr_data;
      p_ready = bus.mem_ready;
      p_rst = rst_n;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog expired");
  end

  // All stimulus tasks start and end just after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_req(input bit rd, input bit wr, input logic [15:0] addr,
                        input logic [15:0] data, output int stalls);
    bus.cpu_addr = addr;
    bus.cpu_wr_data = data;
    bus.cpu_rd = rd;
    bus.cpu_wr = wr;
    if (rd && !wr) exp_q.push_back(ref_mem[addr]);
    if (wr) ref_mem[addr] = data;
    stalls = 0;
    @(negedge clk);
    while (bus.stall && stalls < 500) begin
      stalls++;
      @(negedge clk);
    end
    if (bus.stall) begin
      $display("FAIL req_timeout: addr 0x%0h still stalled after %0d cycles, required completion", addr, stalls);
      $fatal(1, "request timeout");
    end
    @(posedge clk);
    #1;
    bus.cpu_rd = 1'b0;
    bus.cpu_wr = 1'b0;
  endtask

  task automatic do_flush(output int stalls);
    int pulses;
    bus.flush = 1'b1;
    stalls = 0;
    pulses = 0;
    @(negedge clk);
    while (bus.stall && stalls < 2000) begin
      stalls++;
      if (bus.flush_done) pulses++;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;   // dropping flush must not abort the walk
      @(negedge clk);
    end
    if (bus.stall) begin
      $display("FAIL flush_timeout: still stalled after %0d cycles, required completion", stalls);
      $fatal(1, "flush timeout");
    end
    check("flush_done_early", 32'(pulses), 32'(0));
    check("flush_done_pulse", 32'(bus.flush_done), 32'(1));
    @(posedge clk);
    #1;
    @(negedge clk);
    check("flush_done_single", 32'(bus.flush_done), 32'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic check_log(input string name, input int i, input bit wr,
                           input logic [15:0] addr, input logic [15:0] data, input bit chk_data);
    if (mem_log.size() > i) begin
      check({name, "_kind"}, 32'(mem_log[i].wr), 32'(wr));
      check({name, "_addr"}, 32'(mem_log[i].addr), 32'(addr));
      if (chk_data) check({name, "_data"}, 32'(mem_log[i].data), 32'(data));
    end
  endtask

  initial begin
    int s;
    int k;
    logic [15:0] a, d;
    for (int i = 0; i < 65536; i++) begin
      bmem[i] = 16'(i) ^ 16'h5A5A;
      ref_mem[i] = bmem[i];
    end
    bmem[16'h0013] = 16'hBEEF;
    ref_mem[16'h0013] = 16'hBEEF;
    bus.cpu_addr = '0; bus.cpu_wr_data = '0; bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0;
    bus.flush = 1'b0;

    // Reset state
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_stall", 32'(bus.stall), 32'(0));
    check("rst_rd_data", 32'(bus.cpu_rd_data), 32'(0));
    check("rst_mem_rd_req", 32'(bus.mem_rd_req), 32'(0));
    check("rst_mem_wr_req", 32'(bus.mem_wr_req), 32'(0));
    check("rst_flush_done", 32'(bus.flush_done), 32'(0));
    @(posedge clk); #1;

    // Cold read, latency 2: stall = latency + 1
    mem_lat = 2;
    mem_log.delete();
    do_req(1'b1, 1'b0, 16'h0013, 16'h0, s);
    check("cold_rd_stall", 32'(s), 32'(3));
    check("cold_rd_ntxn", 32'(mem_log.size()), 32'(1));
    check_log("cold_rd", 0, 1'b0, 16'h0013, 16'h0, 1'b0);
    do_req(1'b1, 1'b0, 16'h0013, 16'h0, s);
    check("rd_hit_stall", 32'(s), 32'(0));

    // Write hit, then conflict miss with dirty victim
    do_req(1'b0, 1'b1, 16'h0013, 16'h1234, s);
    check("wr_hit_stall", 32'(s), 32'(0));
    mem_log.delete();
    do_req(1'b1, 1'b0, 16'h0023, 16'h0, s);
    check("dirty_miss_stall", 32'(s), 32'(5));
    check("dirty_miss_ntxn", 32'(mem_log.size()), 32'(2));
    check_log("dirty_miss_wb", 0, 1'b1, 16'h0013, 16'h1234, 1'b1);
    check_log("dirty_miss_fill", 1, 1'b0, 16'h0023, 16'h0, 1'b0);

    // Write-allocate miss on an invalid line
    mem_log.delete();
    do_req(1'b0, 1'b1, 16'h0105, 16'hA5A5, s);
    check("wr_alloc_stall", 32'(s), 32'(3));
    check("wr_alloc_ntxn", 32'(mem_log.size()), 32'(1));
    check_log("wr_alloc_fill", 0, 1'b0, 16'h0105, 16'h0, 1'b0);
    do_req(1'b1, 1'b0, 16'h0105, 16'h0, s);
    mem_log.delete();
    do_flush(s);
    check("flush1_stall", 32'(s), 32'(1 + 15 + 2));
    check("flush1_ntxn", 32'(mem_log.size()), 32'(1));
    check_log("flush1_wb", 0, 1'b1, 16'h0105, 16'hA5A5, 1'b1);

    // Flush with dirty lines at index 1 and 7 only
    do_req(1'b0, 1'b1, 16'h0041, 16'h1111, s);
    do_req(1'b0, 1'b1, 16'h0087, 16'h7777, s);
    mem_log.delete();
    do_flush(s);
    check("flush2_stall", 32'(s), 32'(1 + 14 + 2 * 2));
    check("flush2_ntxn", 32'(mem_log.size()), 32'(2));
    check_log("flush2_wb0", 0, 1'b1, 16'h0041, 16'h1111, 1'b1);
    check_log("flush2_wb1", 1, 1'b1, 16'h0087, 16'h7777, 1'b1);

    // Reset in the middle of a write-back
    do_req(1'b0, 1'b1, 16'h0023, 16'h5555, s);
    check("wr_hit2_stall", 32'(s), 32'(0));
    mem_lat = 5;
    bus.cpu_addr = 16'h0033;
    bus.cpu_rd = 1'b1;
    k = 0;
    @(negedge clk);
    while (!bus.mem_wr_req && k < 20) begin
      k++;
      @(negedge clk);
    end
    check("wb_started", 32'(bus.mem_wr_req), 32'(1));
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.cpu_rd = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_wb_mem_wr_req", 32'(bus.mem_wr_req), 32'(0));
    check("rst_wb_mem_rd_req", 32'(bus.mem_rd_req), 32'(0));
    check("rst_wb_stall", 32'(bus.stall), 32'(0));
    check("rst_wb_rd_data", 32'(bus.cpu_rd_data), 32'(0));
    for (int i = 0; i < 65536; i++) ref_mem[i] = bmem[i];
    @(posedge clk); #1;
    mem_lat = 2;
    do_req(1'b1, 1'b0, 16'h0023, 16'h0, s);
    check("post_rst_miss_stall", 32'(s), 32'(3));

    // Slow memory: request held for 11 cycles
    mem_lat = 11;
    do_req(1'b1, 1'b0, 16'h0053, 16'h0, s);
    check("slow_fill_stall", 32'(s), 32'(12));

    // Spurious mem_ready while idle
    spur = 1'b1;
    @(posedge clk); #1;
    spur = 1'b0;
    @(negedge clk);
    check("spur_stall", 32'(bus.stall), 32'(0));
    check("spur_mem_rd_req", 32'(bus.mem_rd_req), 32'(0));
    check("spur_mem_wr_req", 32'(bus.mem_wr_req), 32'(0));
    @(posedge clk); #1;
    do_req(1'b1, 1'b0, 16'h0053, 16'h0, s);
    check("spur_then_hit_stall", 32'(s), 32'(0));

    // Random traffic over four conflicting tags
    for (int i = 0; i < 400; i++) begin
      mem_lat = $urandom_range(1, 4);
      if ($urandom_range(0, 99) < 4) begin
        do_flush(s);
      end else begin
        a = line_addr(16'($urandom_range(0, 3)), 16'($urandom_range(0, 15)), IB);
        d = 16'($urandom);
        case ($urandom_range(0, 2))
          0: do_req(1'b1, 1'b0, a, d, s);
          1: do_req(1'b0, 1'b1, a, d, s);
          default: do_req(1'b1, 1'b1, a, d, s);
        endcase
        if ($urandom_range(0, 3) == 0) idle(1);
      end
    end

    // After a final flush, backing memory must hold every stored value
    mem_lat = 2;
    do_flush(s);
    for (int i = 0; i < 512; i++)
      check("wb_mem_image", 32'(bmem[i]), 32'(ref_mem[i]));
    check("loads_drained", 32'(exp_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
